// File: rtl/lock_code_programmer.sv
// Write side of the digital lock: holds the combination and runs the verify/new/confirm
// reprogramming sequence. Define LOCK_PROG_LOCKOUT_EN to lock out after three failed sessions.
module lock_code_programmer #(
    parameter int                      NUM_DIGITS   = 6,
    parameter logic [NUM_DIGITS*4-1:0] DEFAULT_CODE = 24'h285591
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    prog_req,
    input  logic                    digit_valid,
    input  logic [3:0]              digit_in,
    output logic [NUM_DIGITS*4-1:0] code_out,
    output logic                    code_wr,
    output logic                    busy,
    output logic [1:0]              status,
    output logic [41:0]             hex_out
);
    localparam int            CW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    // Active-low glyphs, bit0 = segment a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] G_U   = ~7'h3E;
    localparam logic [6:0] G_N   = ~7'h54;
    localparam logic [6:0] G_C   = ~7'h39;
    localparam logic [6:0] G_D   = ~7'h5E;
    localparam logic [6:0] G_O_L = ~7'h5C;
    localparam logic [6:0] G_E   = ~7'h79;
    localparam logic [6:0] G_F   = ~7'h71;
    localparam logic [6:0] G_A   = ~7'h77;
    localparam logic [6:0] G_I   = ~7'h30;
    localparam logic [6:0] G_L   = ~7'h38;
    localparam logic [6:0] G_O   = ~7'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VERIFY,
        S_NEW,
        S_CONFIRM,
        S_DONE,
        S_FAIL
`ifdef LOCK_PROG_LOCKOUT_EN
        , S_LOCKOUT
`endif
    } state_t;

    state_t                  state, next_state, fail_target;
    logic [NUM_DIGITS*4-1:0] staging;
    logic [NUM_DIGITS*4-1:0] ref_code;
    logic [CW-1:0]           cnt;
    logic                    mismatch;
    logic                    entry, req_ok, last_dig, dig_bad, dig_mis, mis_final;
    logic [3:0]              ref_dig;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return ~7'h3F;
            4'd1:    return ~7'h06;
            4'd2:    return ~7'h5B;
            4'd3:    return ~7'h4F;
            4'd4:    return ~7'h66;
            4'd5:    return ~7'h6D;
            4'd6:    return ~7'h7D;
            4'd7:    return ~7'h07;
            4'd8:    return ~7'h7F;
            4'd9:    return ~7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

`ifdef LOCK_PROG_LOCKOUT_EN
    logic [1:0] fail_cnt;

    // Counts consecutive failed sessions; a successful commit forgives them
    always_ff @(posedge clk) begin
        if (!rst_n)
            fail_cnt <= 2'd0;
        else if (state != S_DONE && next_state == S_DONE)
            fail_cnt <= 2'd0;
        else if (state != S_FAIL && next_state == S_FAIL)
            fail_cnt <= fail_cnt + 2'd1;
    end

    assign fail_target = (fail_cnt == 2'd2) ? S_LOCKOUT : S_FAIL;
    assign req_ok      = prog_req && (state != S_LOCKOUT);
`else
    assign fail_target = S_FAIL;
    assign req_ok      = prog_req;
`endif

    assign entry    = (state == S_VERIFY) || (state == S_NEW) || (state == S_CONFIRM);
    assign last_dig = entry && digit_valid && (cnt == LAST);
    assign ref_code = (state == S_CONFIRM) ? staging : code_out;
    assign ref_dig  = ref_code[(NUM_DIGITS - 1 - int'(cnt))*4 +: 4];
    assign dig_bad  = (digit_in > 4'd9);
    assign dig_mis  = dig_bad || ((state != S_NEW) && (digit_in != ref_dig));
    assign mis_final = mismatch || dig_mis;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (req_ok)
                    next_state = S_VERIFY;
            end
            S_VERIFY, S_NEW, S_CONFIRM: begin
                if (req_ok)
                    next_state = S_VERIFY;
                else if (last_dig) begin
                    if (mis_final)
                        next_state = fail_target;
                    else if (state == S_VERIFY)
                        next_state = S_NEW;
                    else if (state == S_NEW)
                        next_state = S_CONFIRM;
                    else
                        next_state = S_DONE;
                end
            end
            default: next_state = state;
        endcase
    end

    // A restart always wins over a same-cycle digit, so the digit is simply not consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_out <= DEFAULT_CODE;
            staging  <= '0;
            cnt      <= '0;
            mismatch <= 1'b0;
            code_wr  <= 1'b0;
        end else begin
            code_wr <= 1'b0;
            if (req_ok) begin
                cnt      <= '0;
                mismatch <= 1'b0;
                staging  <= '0;
            end else if (entry && digit_valid) begin
                if (state == S_NEW)
                    staging[(NUM_DIGITS - 1 - int'(cnt))*4 +: 4] <= digit_in;
                if (cnt == LAST) begin
                    cnt      <= '0;
                    mismatch <= 1'b0;
                    if (state == S_CONFIRM && !mis_final) begin
                        code_out <= staging;
                        code_wr  <= 1'b1;
                    end
                end else begin
                    cnt      <= cnt + 1'b1;
                    mismatch <= mis_final;
                end
            end
        end
    end

    always_comb begin
        busy    = 1'b0;
        status  = 2'b00;
        hex_out = {6{SEG_BLANK}};
        case (state)
            S_VERIFY: begin
                busy    = 1'b1;
                status  = 2'b01;
                hex_out = {G_U, {4{SEG_BLANK}}, seg7(4'(cnt))};
            end
            S_NEW: begin
                busy    = 1'b1;
                status  = 2'b01;
                hex_out = {G_N, {4{SEG_BLANK}}, seg7(4'(cnt))};
            end
            S_CONFIRM: begin
                busy    = 1'b1;
                status  = 2'b01;
                hex_out = {G_C, {4{SEG_BLANK}}, seg7(4'(cnt))};
            end
            S_DONE: begin
                status  = 2'b10;
                hex_out = {SEG_BLANK, SEG_BLANK, G_D, G_O_L, G_N, G_E};
            end
            S_FAIL: begin
                status  = 2'b11;
                hex_out = {SEG_BLANK, SEG_BLANK, G_F, G_A, G_I, G_L};
            end
`ifdef LOCK_PROG_LOCKOUT_EN
            S_LOCKOUT: begin
                status  = 2'b11;
                hex_out = {{3{SEG_BLANK}}, G_L, G_O, G_C};
            end
`endif
            default: begin
                busy    = 1'b0;
                status  = 2'b00;
                hex_out = {6{SEG_BLANK}};
            end
        endcase
    end

endmodule

// File: tb/tb_lock_code_programmer.sv
// Scoreboard bench for lock_code_programmer: stimulus pushes expectations, a negedge monitor checks them.
module tb_lock_code_programmer;
    localparam logic [23:0] DEF = 24'h285591;
    localparam logic [6:0]  BL  = 7'h7F;
    localparam logic [41:0] HEX_BLANK = {6{BL}};
    localparam logic [41:0] HEX_DONE  = {BL, BL, ~7'h5E, ~7'h5C, ~7'h54, ~7'h79};
    localparam logic [41:0] HEX_FAIL  = {BL, BL, ~7'h71, ~7'h77, ~7'h30, ~7'h38};
    localparam logic [41:0] HEX_LOC   = {BL, BL, BL, ~7'h38, ~7'h3F, ~7'h39};
    localparam logic [6:0]  GL_U = ~7'h3E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_req = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic [23:0] code_out;
    logic        code_wr;
    logic        busy;
    logic [1:0]  status;
    logic [41:0] hex_out;

    always #5 clk = ~clk;

    lock_code_programmer dut (
        .clk(clk), .rst_n(rst_n), .prog_req(prog_req), .digit_valid(digit_valid),
        .digit_in(digit_in), .code_out(code_out), .code_wr(code_wr), .busy(busy),
        .status(status), .hex_out(hex_out)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        bsy;
        logic [23:0] code;
        logic [41:0] hex;
    } exp_t;

    exp_t        ev_q[$];
    exp_t        snap_q[$];
    logic [23:0] wr_q[$];
    int          total = 0;
    int          bad = 0;
    bit          fin_chk = 0;

    // Reference model state
    logic [23:0] m_code;
`ifdef LOCK_PROG_LOCKOUT_EN
    int          m_fails;
`endif

    // ---------------- monitor ----------------
    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %h need %h", nm, got, need);
        end
    endtask

    task automatic cmp_exp(input string nm, input exp_t e);
        cmp({nm, "_status"}, 64'(status), 64'(e.st));
        cmp({nm, "_busy"}, 64'(busy), 64'(e.bsy));
        cmp({nm, "_code"}, 64'(code_out), 64'(e.code));
        cmp({nm, "_hex"}, 64'(hex_out), 64'(e.hex));
    endtask

    logic [1:0] prev_status = 2'b00;
    logic       prev_wr = 1'b0;
    bit         fin_done = 0;

    always @(negedge clk) begin
        if (code_wr) begin
            if (wr_q.size() == 0)
                cmp("code_wr_unexpected", 64'(code_wr), 64'd0);
            else
                cmp("commit_code", 64'(code_out), 64'(wr_q.pop_front()));
            cmp("code_wr_width", 64'(prev_wr), 64'd0);
        end
        if (rst_n && status !== prev_status && status[1]) begin
            if (ev_q.size() == 0)
                cmp("end_unexpected", 64'(status), 64'(prev_status));
            else
                cmp_exp("session_end", ev_q.pop_front());
        end
        if (snap_q.size() > 0)
            cmp_exp("snapshot", snap_q.pop_front());
        if (fin_chk && !fin_done) begin
            fin_done = 1;
            cmp("events_left", 64'(ev_q.size()), 64'd0);
            cmp("commits_left", 64'(wr_q.size()), 64'd0);
        end
        prev_status = status;
        prev_wr     = code_wr;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [6:0] dig_seg(input int k);
        case (k)
            0: return ~7'h3F;
            1: return ~7'h06;
            2: return ~7'h5B;
            3: return ~7'h4F;
            4: return ~7'h66;
            default: return ~7'h6D;
        endcase
    endfunction

    function automatic logic [41:0] hex_entry(input logic [6:0] g, input int k);
        return {g, BL, BL, BL, BL, dig_seg(k)};
    endfunction

    function automatic bit all_valid(input logic [23:0] c);
        for (int i = 0; i < 6; i++)
            if (c[i*4 +: 4] > 4'd9) return 0;
        return 1;
    endfunction

    function automatic logic [23:0] rand_code();
        logic [23:0] c;
        for (int i = 0; i < 6; i++) c[i*4 +: 4] = 4'($urandom_range(0, 9));
        return c;
    endfunction

    function automatic logic [23:0] perturb(input logic [23:0] c);
        logic [23:0] r = c;
        int p = $urandom_range(0, 5);
        r[p*4 +: 4] = c[p*4 +: 4] + 4'($urandom_range(1, 15));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req();
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        step();
        digit_valid = 1'b0;
        digit_in    = 4'($urandom);
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic do_reset();
        prog_req    = 1'b0;
        digit_valid = 1'b0;
        rst_n       = 1'b0;
        step();
        step();
        m_code = DEF;
`ifdef LOCK_PROG_LOCKOUT_EN
        m_fails = 0;
`endif
        snap_q.push_back('{2'b00, 1'b0, DEF, HEX_BLANK});
        rst_n = 1'b1;
        step();
    endtask

    // Whole session from the user's point of view: three 6-digit entries, digit 0 in the top nibble
    task automatic run_session(input logic [23:0] v, input logic [23:0] n, input logic [23:0] c,
                               input bit do_req);
        logic [23:0] old = m_code;
        bit ok_v = all_valid(v) && (v == m_code);
        bit ok_n = all_valid(n);
        bit ok_c = all_valid(c) && (c == n);
        bit lock = 0;
        if (ok_v && ok_n && ok_c) begin
            ev_q.push_back('{2'b10, 1'b0, n, HEX_DONE});
            wr_q.push_back(n);
            m_code = n;
`ifdef LOCK_PROG_LOCKOUT_EN
            m_fails = 0;
`endif
        end else begin
`ifdef LOCK_PROG_LOCKOUT_EN
            m_fails++;
            lock = (m_fails == 3);
`endif
            ev_q.push_back('{2'b11, 1'b0, old, lock ? HEX_LOC : HEX_FAIL});
        end
        if (do_req) send_req();
        for (int i = 0; i < 6; i++) begin
            send_digit(v[(5-i)*4 +: 4]);
            if (i == 4) snap_q.push_back('{2'b01, 1'b1, old, hex_entry(GL_U, 5)});
        end
        if (ok_v) for (int i = 0; i < 6; i++) send_digit(n[(5-i)*4 +: 4]);
        if (ok_v && ok_n) for (int i = 0; i < 6; i++) send_digit(c[(5-i)*4 +: 4]);
        step();
        if (lock) begin
            send_req();
            snap_q.push_back('{2'b11, 1'b0, old, HEX_LOC});
            step();
            do_reset();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [23:0] v, n, c;
        int p;
        step();
        do_reset();

        run_session(24'h285591, 24'h123456, 24'h123456, 1);   // happy path
        do_reset();
        run_session(24'h285590, 24'h000000, 24'h000000, 1);   // bad verify
        run_session(24'h285591, 24'h123456, 24'h123457, 1);   // confirm mismatch
        run_session(24'h285591, 24'h12A456, 24'h12A456, 1);   // invalid digit in NEW

        // Abort after three digits with a colliding digit that must be dropped
        send_req();
        for (int i = 0; i < 3; i++) send_digit(m_code[(5-i)*4 +: 4]);
        prog_req    = 1'b1;
        digit_valid = 1'b1;
        digit_in    = m_code[8 +: 4];
        step();
        prog_req    = 1'b0;
        digit_valid = 1'b0;
        snap_q.push_back('{2'b01, 1'b1, m_code, hex_entry(GL_U, 0)});
        step();
        run_session(m_code, 24'h654321, 24'h654321, 0);

        for (int k = 0; k < 40; k++) begin
            v = ($urandom_range(0, 9) < 6) ? m_code : perturb(m_code);
            n = rand_code();
            if ($urandom_range(0, 9) < 2) begin
                p = $urandom_range(0, 5);
                n[p*4 +: 4] = 4'($urandom_range(10, 15));
            end
            c = ($urandom_range(0, 9) < 7) ? n : perturb(n);
            run_session(v, n, c, 1);
        end

        fin_chk = 1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
